// File: rtl/lcd_dma_pkg.sv
// lcd_dma_pkg: shared types and defaults for the LCD DMA pixel buffer
package lcd_dma_pkg;
    typedef enum logic {FILL, HOLD} wm_state_e;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_HIGH_WM = 12;
    localparam int DEF_LOW_WM  = 4;
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/lcd_sync_fifo.sv
// lcd_sync_fifo: single-clock FIFO with flush, registered read, level and ovf/unf pulses
module lcd_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic [$clog2(DEPTH):0]  level_nxt,
    output logic                    empty,
    output logic                    full,
    output logic                    ovf,
    output logic                    unf
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic do_wr, do_rd;
    assign level      = wr_ptr - rd_ptr;
    assign empty      = level == '0;
    assign full       = level[AW];
    // a same-cycle read frees the slot, so a write at full still lands
    assign do_rd      = rd_en & ~empty & ~flush;
    assign do_wr      = wr_en & (~full | rd_en) & ~flush;
    assign ovf        = wr_en & full & ~rd_en & ~flush;
    assign unf        = rd_en & empty & ~flush;
    assign wr_ptr_nxt = flush ? '0 : wr_ptr + {{AW{1'b0}}, do_wr};
    assign rd_ptr_nxt = flush ? '0 : rd_ptr + {{AW{1'b0}}, do_rd};
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_valid <= do_rd;
            if (do_rd) rd_data <= mem[rd_ptr[AW-1:0]];
        end
endmodule

// File: rtl/lcd_dma_fifo.sv
// lcd_dma_fifo: dual-panel pixel buffer with hysteretic fetch watermark and v_sync flush
module lcd_dma_fifo
    import lcd_dma_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int HIGH_WM = DEF_HIGH_WM,
    parameter int LOW_WM  = DEF_LOW_WM
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en_upper,
    input  logic                       wr_en_lower,
    input  logic                       dual_mode,
    input  logic                       v_sync,
    input  logic                       rd_en_upper,
    input  logic                       rd_en_lower,
    output logic [DATA_W-1:0]          rd_data_upper,
    output logic [DATA_W-1:0]          rd_data_lower,
    output logic                       rd_valid_upper,
    output logic                       rd_valid_lower,
    output logic                       fifo_watermark,
    output logic                       empty_upper,
    output logic                       empty_lower,
    output logic                       full_upper,
    output logic                       full_lower,
    output logic [lvl_w(DEPTH)-1:0]    level_upper,
    output logic [lvl_w(DEPTH)-1:0]    level_lower,
    output logic                       ovf_sticky,
    output logic                       unf_sticky
);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] HI = LW'(HIGH_WM);
    localparam logic [LW-1:0] LO = LW'(LOW_WM);
    logic [LW-1:0] lu_nxt, ll_nxt;
    logic ovf_u, ovf_l, unf_u, unf_l, wm_set, wm_clr;
    wm_state_e wm_state, wm_nxt;
    lcd_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_upper (
        .clk(HCLK), .rst_n(HRESETn), .flush(v_sync), .wr_en(wr_en_upper), .wr_data(wr_data),
        .rd_en(rd_en_upper), .rd_data(rd_data_upper), .rd_valid(rd_valid_upper),
        .level(level_upper), .level_nxt(lu_nxt), .empty(empty_upper), .full(full_upper),
        .ovf(ovf_u), .unf(unf_u)
    );
    // single-panel mode keeps the lower FIFO flushed, which also masks its strobes
    lcd_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lower (
        .clk(HCLK), .rst_n(HRESETn), .flush(v_sync | ~dual_mode), .wr_en(wr_en_lower), .wr_data(wr_data),
        .rd_en(rd_en_lower), .rd_data(rd_data_lower), .rd_valid(rd_valid_lower),
        .level(level_lower), .level_nxt(ll_nxt), .empty(empty_lower), .full(full_lower),
        .ovf(ovf_l), .unf(unf_l)
    );
    assign wm_set         = lu_nxt >= HI || (dual_mode && ll_nxt >= HI);
    assign wm_clr         = lu_nxt <= LO && (!dual_mode || ll_nxt <= LO);
    assign fifo_watermark = wm_state == HOLD;
    always_comb begin
        wm_nxt = wm_state;
        wm_nxt = v_sync ? FILL : (wm_state == FILL) ? (wm_set ? HOLD : FILL) : (wm_clr ? FILL : HOLD);
    end
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            wm_state   <= FILL;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            wm_state   <= wm_nxt;
            ovf_sticky <= ~v_sync & (ovf_sticky | ovf_u | ovf_l);
            unf_sticky <= ~v_sync & (unf_sticky | unf_u | unf_l);
        end
endmodule

// File: tb/tb_lcd_dma_fifo.sv
// tb_lcd_dma_fifo: randomized and directed scoreboard bench against a queue-based model
`timescale 1ns/1ps
module tb_lcd_dma_fifo;
    logic        HCLK = 1'b0, HRESETn = 1'b1;
    logic [31:0] wr_data = '0;
    logic        wr_en_upper = 0, wr_en_lower = 0, dual_mode = 0, v_sync = 0, rd_en_upper = 0, rd_en_lower = 0;
    logic [31:0] rd_data_upper, rd_data_lower;
    logic        rd_valid_upper, rd_valid_lower, fifo_watermark;
    logic        empty_upper, empty_lower, full_upper, full_lower, ovf_sticky, unf_sticky;
    logic [4:0]  level_upper, level_lower;

    lcd_dma_fifo dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wr_data(wr_data), .wr_en_upper(wr_en_upper),
        .wr_en_lower(wr_en_lower), .dual_mode(dual_mode), .v_sync(v_sync),
        .rd_en_upper(rd_en_upper), .rd_en_lower(rd_en_lower), .rd_data_upper(rd_data_upper),
        .rd_data_lower(rd_data_lower), .rd_valid_upper(rd_valid_upper), .rd_valid_lower(rd_valid_lower),
        .fifo_watermark(fifo_watermark), .empty_upper(empty_upper), .empty_lower(empty_lower),
        .full_upper(full_upper), .full_lower(full_lower), .level_upper(level_upper),
        .level_lower(level_lower), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
    );

    always #5 HCLK = ~HCLK;

    int nvec = 0, nerr = 0;
    logic [31:0] qu[$], ql[$], expu[$], expl[$];
    bit m_wm, m_ovf, m_unf, m_vu, m_vl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("level_upper", 32'(level_upper), 32'(qu.size()));
        chk("level_lower", 32'(level_lower), 32'(ql.size()));
        chk("empty_upper", 32'(empty_upper), 32'(qu.size() == 0));
        chk("empty_lower", 32'(empty_lower), 32'(ql.size() == 0));
        chk("full_upper", 32'(full_upper), 32'(qu.size() == 16));
        chk("full_lower", 32'(full_lower), 32'(ql.size() == 16));
        chk("watermark", 32'(fifo_watermark), 32'(m_wm));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
        chk("unf_sticky", 32'(unf_sticky), 32'(m_unf));
        chk("rd_valid_upper", 32'(rd_valid_upper), 32'(m_vu));
        chk("rd_valid_lower", 32'(rd_valid_lower), 32'(m_vl));
    endtask

    task automatic model_clear();
        qu.delete(); ql.delete();
        m_wm = 0; m_ovf = 0; m_unf = 0; m_vu = 0; m_vl = 0;
    endtask

    task automatic model(input bit wu, wl, ru, rl, vs, input logic [31:0] d);
        bit wok;
        if (vs) begin
            model_clear();
            return;
        end
        wok = wu && (qu.size() < 16 || ru);
        if (wu && qu.size() == 16 && !ru) m_ovf = 1;
        if (ru && qu.size() == 0) m_unf = 1;
        m_vu = ru && qu.size() > 0;
        if (m_vu) expu.push_back(qu.pop_front());
        if (wok) qu.push_back(d);
        if (!dual_mode) begin
            ql.delete();
            m_vl = 0;
        end else begin
            wok = wl && (ql.size() < 16 || rl);
            if (wl && ql.size() == 16 && !rl) m_ovf = 1;
            if (rl && ql.size() == 0) m_unf = 1;
            m_vl = rl && ql.size() > 0;
            if (m_vl) expl.push_back(ql.pop_front());
            if (wok) ql.push_back(d);
        end
        if (!m_wm && (qu.size() >= 12 || (dual_mode && ql.size() >= 12))) m_wm = 1;
        else if (m_wm && qu.size() <= 4 && (!dual_mode || ql.size() <= 4)) m_wm = 0;
    endtask

    task automatic step(input bit wu, wl, ru, rl, vs, input logic [31:0] d);
        wr_en_upper = wu; wr_en_lower = wl; rd_en_upper = ru; rd_en_lower = rl;
        v_sync = vs; wr_data = d;
        model(wu, wl, ru, rl, vs, d);
        @(negedge HCLK);
        check_state();
    endtask

    task automatic new_frame(input bit dm);
        dual_mode = dm;
        step(0, 0, 0, 0, 1, 32'h0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_level_upper", 32'(level_upper), 0);
        chk("rst_level_lower", 32'(level_lower), 0);
        chk("rst_empty", {30'd0, empty_upper, empty_lower}, 32'h3);
        chk("rst_full", {30'd0, full_upper, full_lower}, 0);
        chk("rst_rd_data_upper", rd_data_upper, 0);
        chk("rst_rd_data_lower", rd_data_lower, 0);
        chk("rst_rd_valid", {30'd0, rd_valid_upper, rd_valid_lower}, 0);
        chk("rst_watermark", 32'(fifo_watermark), 0);
        chk("rst_sticky", {30'd0, ovf_sticky, unf_sticky}, 0);
    endtask

    // read-data scoreboard: pops whenever the DUT presents a valid word
    initial forever begin
        @(negedge HCLK);
        #1;
        if (HRESETn) begin
            if (rd_valid_upper) begin
                if (expu.size() == 0) chk("rd_upper_spurious", 32'(rd_valid_upper), 0);
                else chk("rd_data_upper", rd_data_upper, expu.pop_front());
            end
            if (rd_valid_lower) begin
                if (expl.size() == 0) chk("rd_lower_spurious", 32'(rd_valid_lower), 0);
                else chk("rd_data_lower", rd_data_lower, expl.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wp, rp;
        #1 HRESETn = 1'b0;
        #1 check_reset_outputs();
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_clear();

        // single-panel fill, trailing write, drain through the low watermark
        new_frame(0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 1, 0, 32'h1000_0000 + i);
            if (i == 10) chk("wm_below_high", 32'(fifo_watermark), 0);
        end
        chk("wm_set_single", 32'(fifo_watermark), 1);
        chk("lower_ignored", 32'(level_lower), 0);
        step(1, 0, 0, 0, 0, 32'h1000_000C);
        chk("trailing_level", 32'(level_upper), 13);
        chk("trailing_no_ovf", 32'(ovf_sticky), 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, 1, 0, 32'h0);
            if (i == 7) chk("wm_hold_at5", 32'(fifo_watermark), 1);
        end
        chk("wm_clear_at4", 32'(fifo_watermark), 0);
        chk("no_unf_single", 32'(unf_sticky), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 32'h0);

        // dual-panel alternating fill, hysteresis needs both panels low
        new_frame(1);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0, 32'hB000_0000 + i);
            if (i == 11) chk("wm_on_12th_lower", 32'(fifo_watermark), 1);
            else chk("wm_before_12th", 32'(fifo_watermark), 0);
            step(1, 0, 0, 0, 0, 32'hA000_0000 + i);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 1, 0, 32'h0);
        chk("wm_hold_u5_l4", 32'(fifo_watermark), 1);
        step(0, 0, 1, 0, 0, 32'h0);
        chk("wm_clear_both4", 32'(fifo_watermark), 0);

        // overflow, simultaneous at full, lower underflow
        new_frame(1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, $urandom);
        chk("full_after16", 32'(full_upper), 1);
        step(1, 0, 1, 0, 0, 32'h5151_5151);
        chk("simul_full_level", 32'(level_upper), 16);
        chk("simul_full_no_ovf", 32'(ovf_sticky), 0);
        step(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        chk("ovf_set", 32'(ovf_sticky), 1);
        chk("ovf_level", 32'(level_upper), 16);
        step(0, 0, 0, 1, 0, 32'h0);
        chk("unf_valid_lower", 32'(rd_valid_lower), 0);
        chk("unf_set", 32'(unf_sticky), 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 32'h0);

        // v_sync flush with a write in the same cycle
        new_frame(1);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, $urandom);
        step(0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0);
        chk("pre_flush_level", 32'(level_upper), 10);
        chk("pre_flush_wm", 32'(fifo_watermark), 1);
        step(1, 0, 0, 0, 1, 32'h7777_7777);
        chk("flush_level", 32'(level_upper), 0);
        chk("flush_wm", 32'(fifo_watermark), 0);
        chk("flush_sticky", {30'd0, ovf_sticky, unf_sticky}, 0);

        // asynchronous reset mid-traffic at level 7
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 32'hC000_0001 + i);
        step(1, 0, 1, 1, 0, 32'hC000_0008);
        chk("pre_reset_level", 32'(level_upper), 7);
        step(0, 0, 0, 1, 0, 32'h0);
        wr_en_upper = 0; rd_en_lower = 0;
        #2 HRESETn = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        expu.delete(); expl.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;

        // randomized traffic in frames with varying read/write bias
        for (int f = 0; f < 8; f++) begin
            new_frame(1'($urandom_range(0, 1)));
            for (int c = 0; c < 400; c++) begin
                if (c % 100 == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin wp = 75; rp = 30; end
                        1: begin wp = 30; rp = 75; end
                        default: begin wp = 55; rp = 50; end
                    endcase
                end
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < wp,
                     $urandom_range(0, 99) < rp, $urandom_range(0, 99) < rp,
                     $urandom_range(0, 299) == 0, $urandom);
            end
        end
        step(0, 0, 0, 0, 0, 32'h0);
        @(negedge HCLK);
        chk("scoreboard_drained", 32'(expu.size() + expl.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
